// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the instruction memory loader: instruction width,
// the reset-fill NOP encoding, and the loader FSM states.
package instr_mem_loader_pkg;

  localparam int InstructionSize = 32;

  // addi x0, x0, 0
  localparam logic [InstructionSize-1:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } loader_state_e;

  // Assembles four little-endian bytes into one instruction word.
  function automatic logic [InstructionSize-1:0] pack_le(
    input logic [7:0] b0,
    input logic [7:0] b1,
    input logic [7:0] b2,
    input logic [7:0] b3
  );
    return {b3, b2, b1, b0};
  endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// Bundles the pad-side load signals and the core-side fetch signals of the
// instruction memory loader.
interface instr_mem_loader_if
  import instr_mem_loader_pkg::*;
#(
  parameter int DEPTH_WORDS = 16
);
  localparam int ADDR_WIDTH = $clog2(DEPTH_WORDS);

  logic                       load_start;
  logic                       load_valid;
  logic [7:0]                 load_byte;
  logic                       load_end;
  logic [31:0]                fetch_addr;
  logic [InstructionSize-1:0] fetch_instr;
  logic                       core_rst;
  logic [ADDR_WIDTH:0]        word_count;
  logic                       overflow;

  modport master (
    output load_start, load_valid, load_byte, load_end, fetch_addr,
    input  fetch_instr, core_rst, word_count, overflow
  );

  modport slave (
    input  load_start, load_valid, load_byte, load_end, fetch_addr,
    output fetch_instr, core_rst, word_count, overflow
  );

endinterface

// File: rtl/instr_mem_loader_byte_assembler.sv
// Collects a byte stream into 32-bit words, lane 0 first; flags the cycle in
// which the fourth byte arrives together with the completed word.
module instr_mem_loader_byte_assembler
  import instr_mem_loader_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       valid,
  input  logic [7:0]                 data_byte,
  output logic [InstructionSize-1:0] word,
  output logic                       word_done
);

  logic [1:0]  byte_cnt;
  logic [23:0] lanes_lo;

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
    end else if (valid) begin
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

  // Only lanes 0..2 are stored; lane 3 is taken straight from the input.
  always_ff @(posedge clk) begin
    if (valid && byte_cnt != 2'd3) begin
      lanes_lo[{byte_cnt, 3'b000} +: 8] <= data_byte;
    end
  end

  assign word      = pack_le(lanes_lo[7:0], lanes_lo[15:8], lanes_lo[23:16], data_byte);
  assign word_done = valid && (byte_cnt == 2'd3);

endmodule

// File: rtl/instr_mem_loader.sv
// Instruction-fetch responder: loads a program byte-serially from the pads,
// holds the core in reset while loading, then serves combinational fetches.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int DEPTH_WORDS = 16
)(
  input  logic               clk,
  input  logic               rst,
  instr_mem_loader_if.slave  bus
);

  localparam int ADDR_WIDTH = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_WIDTH:0] FULL_PTR = (ADDR_WIDTH+1)'(DEPTH_WORDS);

  loader_state_e state_q, state_d;

  logic [InstructionSize-1:0] mem [DEPTH_WORDS];
  logic [ADDR_WIDTH:0]        word_ptr;
  logic [ADDR_WIDTH:0]        word_count_q;
  logic                       overflow_q;

  logic                       in_load;
  logic                       full;
  logic                       asm_clear;
  logic                       asm_valid;
  logic [InstructionSize-1:0] asm_word;
  logic                       word_done;
  logic                       addr_in_range;
  logic                       unused_addr_bits;

  assign in_load   = (state_q == LOAD);
  assign full      = (word_ptr == FULL_PTR);
  assign asm_clear = bus.load_start || (in_load && bus.load_end);
  // A restart in the same cycle as a byte drops that byte.
  assign asm_valid = in_load && bus.load_valid && !full && !bus.load_start;

  instr_mem_loader_byte_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .clear     (asm_clear),
    .valid     (asm_valid),
    .data_byte (bus.load_byte),
    .word      (asm_word),
    .word_done (word_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.load_start) state_d = LOAD;
      LOAD: begin
        if (bus.load_start)    state_d = LOAD;
        else if (bus.load_end) state_d = RUN;
      end
      RUN:  if (bus.load_start) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_ptr     <= '0;
      word_count_q <= '0;
      overflow_q   <= 1'b0;
    end else if (bus.load_start) begin
      word_ptr   <= '0;
      overflow_q <= 1'b0;
    end else if (in_load) begin
      if (bus.load_valid && full) overflow_q <= 1'b1;
      if (word_done) word_ptr <= word_ptr + 1'b1;
      // The byte arriving alongside load_end is counted if it completes a word.
      if (bus.load_end) word_count_q <= word_ptr + {{ADDR_WIDTH{1'b0}}, word_done};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= NOP;
    end else if (word_done) begin
      mem[word_ptr[ADDR_WIDTH-1:0]] <= asm_word;
    end
  end

  assign addr_in_range    = (bus.fetch_addr[31:ADDR_WIDTH+2] == '0);
  assign unused_addr_bits = ^bus.fetch_addr[1:0];

  always_comb begin
    bus.fetch_instr = NOP;
    if (state_q == RUN && addr_in_range) begin
      bus.fetch_instr = mem[bus.fetch_addr[ADDR_WIDTH+1:2]];
    end
  end

  assign bus.core_rst   = (state_q != RUN);
  assign bus.word_count = word_count_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: directed program loads plus random
// loads, checked against a byte-list reference model of the memory.
module tb_instr_mem_loader;
  import instr_mem_loader_pkg::*;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_mem_loader_if #(.DEPTH_WORDS(DEPTH)) bus();

  instr_mem_loader #(.DEPTH_WORDS(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          cyc;
    int          kind;   // 0 fetch_instr, 1 core_rst, 2 word_count, 3 overflow
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares every expectation registered for the current cycle.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      case (e.kind)
        0:       act = bus.fetch_instr;
        1:       act = {31'b0, bus.core_rst};
        2:       act = 32'(bus.word_count);
        default: act = {31'b0, bus.overflow};
      endcase
      checks++;
      if (e.cyc != cyc || act !== e.exp) begin
        failures++;
        $display("FAIL %s cyc=%0d (queued %0d) got=%h want=%h", e.name, cyc, e.cyc, act, e.exp);
      end
    end
  end

  // Reference model: the program is the list of accepted bytes; words are
  // consecutive groups of four, and only whole groups ever reach memory.
  logic [31:0] m_mem [DEPTH];
  logic [7:0]  m_bytes[$];
  bit          m_run, m_loading, m_ovf;
  int          m_wc;

  function automatic void m_commit();
    for (int i = 0; i < m_bytes.size() / 4; i++)
      m_mem[i] = {m_bytes[4*i+3], m_bytes[4*i+2], m_bytes[4*i+1], m_bytes[4*i]};
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = NOP;
    m_bytes.delete();
    m_run = 0; m_loading = 0; m_ovf = 0; m_wc = 0;
  endfunction

  function automatic logic [31:0] m_fetch(logic [31:0] a);
    if (!m_run || a >= 32'(4 * DEPTH)) return NOP;
    return m_mem[int'(a >> 2)];
  endfunction

  task automatic step(input bit s, input bit v, input logic [7:0] b, input bit e);
    bus.load_start = s;
    bus.load_valid = v;
    bus.load_byte  = b;
    bus.load_end   = e;
    @(posedge clk);
    #1;
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_byte  = 8'h00;
    bus.load_end   = 1'b0;
    if (rst) begin
      m_reset();
    end else if (s) begin
      if (m_loading) m_commit();
      m_bytes.delete();
      m_ovf = 0; m_run = 0; m_loading = 1;
    end else if (m_loading) begin
      if (v) begin
        if (m_bytes.size() >= 4 * DEPTH) m_ovf = 1;
        else m_bytes.push_back(b);
      end
      if (e) begin
        m_commit();
        m_wc = m_bytes.size() / 4;
        m_bytes.delete();
        m_run = 1; m_loading = 0;
      end
    end
  endtask

  task automatic expect_val(input int kind, input logic [31:0] exp, input string name);
    exp_t e;
    e.cyc = cyc; e.kind = kind; e.exp = exp; e.name = name;
    sb.push_back(e);
  endtask

  task automatic check_status(input string tag);
    expect_val(1, {31'b0, !m_run}, {tag, ".core_rst"});
    expect_val(2, 32'(m_wc), {tag, ".word_count"});
    expect_val(3, {31'b0, m_ovf}, {tag, ".overflow"});
  endtask

  task automatic check_fetch(input logic [31:0] addr, input string tag);
    bus.fetch_addr = addr;
    expect_val(0, m_fetch(addr), {tag, ".fetch_instr"});
    step(0, 0, 8'h00, 0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      step(0, 0, 8'h00, 0);
      bus.fetch_addr = 32'h0;
      check_status("reset");
      expect_val(0, NOP, "reset.fetch_instr");
    end
    rst = 1'b0;
  endtask

  task automatic load_prog(input logic [7:0] bytes[$], input bit merge_end, input int gap_max);
    int n;
    n = bytes.size();
    step(1, 0, 8'h00, 0);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(gap_max, 0)) step(0, 0, 8'h00, 0);
      step(0, 1, bytes[i], merge_end && (i == n - 1));
    end
    if (!merge_end || n == 0) step(0, 0, 8'h00, 1);
  endtask

  initial begin
    logic [7:0] q[$];
    int         mode, len;

    rst = 1'b1;
    bus.load_start = 0; bus.load_valid = 0; bus.load_byte = 0; bus.load_end = 0;
    bus.fetch_addr = 32'h0;
    m_reset();

    // Reset held for three cycles, then idle.
    do_reset(3);
    check_fetch(32'h0, "idle");
    check_status("idle");

    // Two-word program.
    q = '{8'h93, 8'h00, 8'h50, 8'h00, 8'hB3, 8'h80, 8'h10, 8'h00};
    load_prog(q, 0, 0);
    check_status("prog2");
    expect_val(0, 32'h0050_0093, "prog2.w0_const");
    check_fetch(32'h0, "prog2.a0");
    expect_val(0, 32'h0010_80B3, "prog2.w1_const");
    check_fetch(32'h4, "prog2.a4");
    check_fetch(32'h6, "prog2.a6");

    // Five bytes: trailing partial word discarded.
    do_reset(1);
    q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    load_prog(q, 0, 1);
    check_status("partial");
    expect_val(0, 32'h4433_2211, "partial.w0_const");
    check_fetch(32'h0, "partial.a0");
    expect_val(0, NOP, "partial.w1_nop");
    check_fetch(32'h4, "partial.a4");

    // Fourth byte together with load_end.
    q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    load_prog(q, 1, 0);
    expect_val(2, 32'd1, "merge.word_count_const");
    check_status("merge");
    check_fetch(32'h0, "merge.a0");

    // 68 bytes into a 16-word memory.
    q.delete();
    for (int i = 0; i < 68; i++) q.push_back(8'(i + 1));
    load_prog(q, 0, 0);
    expect_val(3, 32'd1, "full.overflow_const");
    check_status("full");
    expect_val(0, {8'd64, 8'd63, 8'd62, 8'd61}, "full.w15_const");
    check_fetch(32'h3C, "full.a3c");
    check_fetch(32'h40, "full.a40");
    check_fetch(32'hFFFF_FFFC, "full.high");

    // load_start from RUN, then rst mid-load with two bytes pending.
    check_status("run");
    bus.fetch_addr = 32'h0;
    expect_val(1, 32'd0, "restart.core_rst_before");
    step(1, 0, 8'h00, 0);
    expect_val(1, 32'd1, "restart.core_rst_after");
    check_fetch(32'h0, "restart");
    step(0, 1, 8'hEE, 0);
    step(0, 1, 8'hFF, 0);
    do_reset(1);
    check_status("after_rst");
    q.delete();
    load_prog(q, 0, 0);
    check_status("empty");
    for (int a = 0; a < 4 * DEPTH; a += 12) check_fetch(32'(a), "empty");

    // Random loads with gaps, merged ends, restarts and resets.
    for (int it = 0; it < 12; it++) begin
      mode = $urandom_range(3, 0);
      if (mode == 1) begin
        step(1, 0, 8'h00, 0);
        repeat ($urandom_range(9, 1)) step(0, 1, 8'($urandom), 0);
        do_reset(1);
      end else if (mode == 2) begin
        step(1, 0, 8'h00, 0);
        repeat ($urandom_range(12, 1)) step(0, 1, 8'($urandom), 0);
      end
      len = $urandom_range(70, 0);
      q.delete();
      for (int i = 0; i < len; i++) q.push_back(8'($urandom));
      load_prog(q, $urandom_range(1, 0) == 1, 2);
      check_status("rand");
      for (int k = 0; k < 6; k++) begin
        if (k == 5) check_fetch($urandom, "rand.wide");
        else check_fetch(32'($urandom_range(4 * DEPTH + 8, 0)), "rand");
      end
    end

    repeat (3) step(0, 0, 8'h00, 0);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
Responder end of the core's instruction-fetch interface.
- Holds a small instruction memory that is filled byte-serially from the 8-bit pad input.
- Keeps the core in reset while the program is loading.
- Once loading ends, serves combinational 32-bit instruction reads for the single-cycle datapath's fetch address.
- Sits between the top-level pad inputs and the core, replacing the direct ui_in-to-instr hookup.

Parameters:
DEPTH_WORDS, 16, number of 32-bit instruction words stored; power of two, minimum 2.
ADDR_WIDTH, $clog2(DEPTH_WORDS), word-index width; derived, not overridden.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
load_start  in  1  one-cycle pulse; starts a program load
load_valid  in  1  load_byte is valid this cycle
load_byte  in  8  program byte, little-endian within each word
load_end  in  1  one-cycle pulse; ends the load and releases the core
fetch_addr  in  32  core PC (byte address)
fetch_instr  out  32  instruction word for fetch_addr
core_rst  out  1  reset to the core, active-high
word_count  out  ADDR_WIDTH+1  number of complete words loaded
overflow  out  1  sticky flag; a byte arrived with memory full

Behaviour:
- FSM states: IDLE, LOAD, RUN. State, memory, and counters are all registered on posedge clk.
- Reset:
  - state=IDLE, all memory words=NOP (0x00000013), byte_cnt=0, word_ptr=0, word_count=0, overflow=0.
  - Outputs after reset: core_rst=1, fetch_instr=NOP.
- core_rst = (state != RUN), decoded from the state register with no extra delay.
  - First cycle in RUN: core leaves reset with PC=0 and fetches word 0.
- IDLE:
  - load_start -> LOAD. Clears byte_cnt, word_ptr, overflow.
  - load_valid and load_end are ignored.
- LOAD, on each load_valid:
  - Byte goes into lane byte_cnt of the assembly register (lane 0 = bits 7:0).
  - byte_cnt increments modulo 4.
  - On the 4th byte, the assembled word is written to mem[word_ptr] in the same edge and word_ptr increments.
  - Memory is not cleared on load_start; words not rewritten keep their previous contents.
- Full: if word_ptr == DEPTH_WORDS and load_valid is high, the byte is dropped, overflow is set and stays set until the next load_start or rst, and word_ptr saturates.
- load_end in LOAD -> RUN.
  - word_count <= word_ptr.
  - A partial word (byte_cnt != 0) is discarded and byte_cnt is cleared.
- load_valid and load_end in the same cycle: the byte is accepted first. If it completes a word, that word is written and counted in word_count. Then the FSM goes to RUN.
- load_start while in LOAD: the load restarts (pointers cleared, state stays LOAD).
- RUN:
  - fetch_instr = mem[fetch_addr[ADDR_WIDTH+1:2]] combinationally, zero-cycle latency.
  - fetch_addr[1:0] is ignored.
  - If fetch_addr >= 4*DEPTH_WORDS, fetch_instr = NOP.
  - load_start -> LOAD. core_rst rises the next cycle, when the state register updates.
- Outside RUN, fetch_instr = NOP.
- rst in any state aborts immediately to the reset condition, including memory reinitialised to NOP.
- load_end outside LOAD is ignored.

Decomposition:
- Shared rv32i package:
  - InstructionSize=32.
  - NOP constant 32'h00000013.
  - loader state enum {IDLE, LOAD, RUN}.
- One sub-module: byte_assembler. Holds the 2-bit byte counter and 32-bit assembly register. Inputs: clear, valid, byte. Outputs: word, word_done pulse.
- Memory array, word pointer, and FSM stay in instr_mem_loader.

Test Plan:
1. Reset, then hold for 3 cycles -> core_rst=1, fetch_instr=0x00000013, word_count=0, overflow=0.
2. load_start; bytes 0x93,0x00,0x50,0x00, then 0xB3,0x80,0x10,0x00; load_end -> word_count=2 and core_rst=0 in the first RUN cycle; fetch_addr=0 gives 0x00500093, fetch_addr=4 gives 0x001080B3, fetch_addr=6 gives 0x001080B3.
3. Load 5 bytes (0x11,0x22,0x33,0x44,0x55), then load_end -> word_count=1; mem[0]=0x44332211; the trailing 0x55 is discarded and fetch_addr=4 gives 0x00000013.
4. load_valid with the 4th byte in the same cycle as load_end -> word written, word_count=1, state RUN on the next edge.
5. DEPTH_WORDS=16: load 68 bytes -> word_count=16, overflow=1, mem[15] holds bytes 60..63; fetch_addr=0x40 gives NOP.
6. In RUN, pulse load_start -> core_rst=1 from the next cycle, fetch_instr=NOP. Then assert rst mid-load with 2 bytes pending -> IDLE, word_count=0, all fetches return NOP after the next load.
